// File: rtl/irq_capture_encoder.sv
// Four-line request capture front end: synchronise, capture into pending,
// priority-encode the highest unmasked pending line behind a valid/ack handshake.
module irq_capture_encoder #(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE_MODE   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_in,
   input  logic [3:0] mask,
   input  logic       ack,
   output logic [1:0] code,
   output logic       valid,
   output logic [3:0] pending,
   output logic       overflow
);

   logic [3:0] sync;
   logic [3:0] ev;
   logic [3:0] clr;
   logic [3:0] ov_hit;
   logic [3:0] cand;
   logic [3:0] pending_reg;
   logic [3:0] pending_next;
   logic [1:0] code_reg;
   logic [1:0] code_next;
   logic       valid_reg;
   logic       valid_next;
   logic       overflow_reg;
   logic       acc;
   logic       load;

   genvar gi;

   // Per-line synchroniser chain; the last stage is the only one logic may use.
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sync
         logic [SYNC_STAGES-1:0] chain_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               chain_reg <= '0;
            end else begin
               chain_reg <= {chain_reg[SYNC_STAGES-2:0], req_in[gi]};
            end
         end

         assign sync[gi] = chain_reg[SYNC_STAGES-1];
      end
   endgenerate

   generate
      if (EDGE_MODE) begin : g_edge
         logic [3:0] sync_d_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync_d_reg <= '0;
            end else begin
               sync_d_reg <= sync;
            end
         end

         assign ev = sync & ~sync_d_reg;
      end else begin : g_level
         assign ev = sync;
      end
   endgenerate

   assign acc = valid_reg & ack;

   // A fresh event on a line being consumed re-arms it rather than counting as lost.
   generate
      for (gi = 0; gi < 4; gi++) begin : g_pend
         assign clr[gi]          = acc & (code_reg == 2'(gi));
         assign pending_next[gi] = ev[gi] | (pending_reg[gi] & ~clr[gi]);
         assign ov_hit[gi]       = ev[gi] & pending_reg[gi] & ~clr[gi];
      end
   endgenerate

   // Only already-registered events compete; this cycle's events wait one edge.
   assign cand = pending_reg & ~clr & ~mask;
   assign load = ~valid_reg | acc;

   always_comb begin
      code_next  = code_reg;
      valid_next = valid_reg;
      if (load) begin
         valid_next = |cand;
         code_next  = 2'd0;
         for (int i = 0; i < 4; i++) begin
            if (cand[i]) begin
               code_next = 2'(i);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_reg  <= '0;
         code_reg     <= '0;
         valid_reg    <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         pending_reg  <= pending_next;
         code_reg     <= code_next;
         valid_reg    <= valid_next;
         overflow_reg <= overflow_reg | (|ov_hit);
      end
   end

   assign code     = code_reg;
   assign valid    = valid_reg;
   assign pending  = pending_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_irq_capture_encoder.sv
// Directed bench for irq_capture_encoder with default parameters; observes
// {overflow, valid, code, pending} as one 8-bit word at each falling edge.
module tb_irq_capture_encoder;

   logic       clk;
   logic       rst;
   logic [3:0] req_in;
   logic [3:0] mask;
   logic       ack;
   logic [1:0] code;
   logic       valid;
   logic [3:0] pending;
   logic       overflow;

   int total;
   int bad;

   irq_capture_encoder #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_in   (req_in),
      .mask     (mask),
      .ack      (ack),
      .code     (code),
      .valid    (valid),
      .pending  (pending),
      .overflow (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      logic [7:0] obs;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_in = (i % 2 == 0) ? 4'hF : 4'h0;
         @(negedge clk);
         obs = {overflow, valid, code, pending};
         total++;
         if (obs !== 8'b0_0_00_0000) begin
            bad++;
            $display("FAIL reset_assert%0d got=%b exp=%b", i, obs, 8'b0_0_00_0000);
         end
      end
      req_in = 4'h0;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b0_0_00_0000) begin
         bad++;
         $display("FAIL reset_release got=%b exp=%b", obs, 8'b0_0_00_0000);
      end
      $display("test_reset done");
   endtask

   task automatic test_latency();
      logic [7:0] obs;
      logic [7:0] exp_tab [4];
      exp_tab[0] = 8'b0_0_00_0000;
      exp_tab[1] = 8'b0_0_00_0000;
      exp_tab[2] = 8'b0_0_00_0110;
      exp_tab[3] = 8'b0_1_10_0110;
      req_in = 4'b0110;
      for (int e = 0; e < 4; e++) begin
         @(negedge clk);
         obs = {overflow, valid, code, pending};
         total++;
         if (obs !== exp_tab[e]) begin
            bad++;
            $display("FAIL latency_edge%0d got=%b exp=%b", e + 1, obs, exp_tab[e]);
         end
      end
      ack = 1'b1;
      @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b0_1_01_0010) begin
         bad++;
         $display("FAIL latency_ack1 got=%b exp=%b", obs, 8'b0_1_01_0010);
      end
      @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b0_0_00_0000) begin
         bad++;
         $display("FAIL latency_ack2 got=%b exp=%b", obs, 8'b0_0_00_0000);
      end
      ack = 1'b0;
      req_in = 4'h0;
      repeat (3) @(negedge clk);
      $display("test_latency done");
   endtask

   task automatic test_priority();
      logic [7:0] obs;
      logic [7:0] exp_tab [4];
      exp_tab[0] = 8'b0_1_11_1101;
      exp_tab[1] = 8'b0_1_10_0101;
      exp_tab[2] = 8'b0_1_00_0001;
      exp_tab[3] = 8'b0_0_00_0000;
      req_in = 4'b1101;
      repeat (4) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         if (s > 0) begin
            ack = 1'b1;
            @(negedge clk);
         end
         obs = {overflow, valid, code, pending};
         total++;
         if (obs !== exp_tab[s]) begin
            bad++;
            $display("FAIL priority_step%0d got=%b exp=%b", s, obs, exp_tab[s]);
         end
      end
      ack = 1'b0;
      req_in = 4'h0;
      repeat (3) @(negedge clk);
      $display("test_priority done");
   endtask

   task automatic test_mask();
      logic [7:0] obs;
      mask = 4'b1000;
      req_in = 4'b1000;
      repeat (4) @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b0_0_00_1000) begin
         bad++;
         $display("FAIL mask_captured got=%b exp=%b", obs, 8'b0_0_00_1000);
      end
      repeat (3) @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b0_0_00_1000) begin
         bad++;
         $display("FAIL mask_held got=%b exp=%b", obs, 8'b0_0_00_1000);
      end
      mask = 4'b0000;
      @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b0_1_11_1000) begin
         bad++;
         $display("FAIL mask_unmask got=%b exp=%b", obs, 8'b0_1_11_1000);
      end
      ack = 1'b1;
      @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b0_0_00_0000) begin
         bad++;
         $display("FAIL mask_consume got=%b exp=%b", obs, 8'b0_0_00_0000);
      end
      ack = 1'b0;
      req_in = 4'h0;
      repeat (3) @(negedge clk);
      $display("test_mask done");
   endtask

   task automatic test_hold_overflow();
      logic [7:0] obs;
      req_in = 4'b0001;
      repeat (4) @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b0_1_00_0001) begin
         bad++;
         $display("FAIL hold_low_presented got=%b exp=%b", obs, 8'b0_1_00_0001);
      end
      req_in = 4'b1001;
      repeat (4) @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b0_1_00_1001) begin
         bad++;
         $display("FAIL hold_stable got=%b exp=%b", obs, 8'b0_1_00_1001);
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b0_1_11_1000) begin
         bad++;
         $display("FAIL hold_next_code got=%b exp=%b", obs, 8'b0_1_11_1000);
      end
      req_in = 4'b0001;
      repeat (3) @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b0_1_11_1000) begin
         bad++;
         $display("FAIL hold_fall_no_event got=%b exp=%b", obs, 8'b0_1_11_1000);
      end
      req_in = 4'b1001;
      repeat (4) @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b1_1_11_1000) begin
         bad++;
         $display("FAIL overflow_set got=%b exp=%b", obs, 8'b1_1_11_1000);
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b1_0_00_0000) begin
         bad++;
         $display("FAIL overflow_after_ack got=%b exp=%b", obs, 8'b1_0_00_0000);
      end
      repeat (2) @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b1_0_00_0000) begin
         bad++;
         $display("FAIL overflow_sticky got=%b exp=%b", obs, 8'b1_0_00_0000);
      end
      req_in = 4'h0;
      repeat (3) @(negedge clk);
      $display("test_hold_overflow done");
   endtask

   task automatic test_reset_mid();
      logic [7:0] obs;
      req_in = 4'b0110;
      repeat (4) @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b1_1_10_0110) begin
         bad++;
         $display("FAIL midrst_before got=%b exp=%b", obs, 8'b1_1_10_0110);
      end
      #2 rst = 1'b1;
      #1;
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b0_0_00_0000) begin
         bad++;
         $display("FAIL midrst_immediate got=%b exp=%b", obs, 8'b0_0_00_0000);
      end
      req_in = 4'h0;
      @(negedge clk);
      rst = 1'b0;
      ack = 1'b1;
      repeat (6) @(negedge clk);
      obs = {overflow, valid, code, pending};
      total++;
      if (obs !== 8'b0_0_00_0000) begin
         bad++;
         $display("FAIL midrst_after got=%b exp=%b", obs, 8'b0_0_00_0000);
      end
      ack = 1'b0;
      $display("test_reset_mid done");
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rst    = 1'b1;
      req_in = 4'h0;
      mask   = 4'h0;
      ack    = 1'b0;
      test_reset();
      test_latency();
      test_priority();
      test_mask();
      test_hold_overflow();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
